// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core front end: opcode and
// funct constants, the fetch state encoding, the default reset PC and the
// branch-offset helper used by the next-PC logic.
package mips_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;

  // SPECIAL funct codes (instruction[5:0])
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  // Word-aligned PC loaded on reset unless overridden
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  // Sign-extended 16-bit immediate scaled to a byte offset
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit
// (master) and the instruction memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/fetch_unit_npc_sel.sv
// Next-PC selection: jump/branch target arithmetic, branch condition
// evaluation and the priority mux JR > J/JAL > taken branch > pc+4.
// All adders are 32 bits wide with the carry dropped.
import mips_pkg::*;

module npc_sel (
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_index,
  input  logic        pc_mux_2,
  input  logic        pc_mux_3,
  input  logic        beq,
  input  logic        bne,
  input  logic        blez,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] npc,
  output logic        branch_taken
);

  logic        rs_eq_rt;
  logic        rs_le_zero;
  logic [31:0] jr_target;
  logic [31:0] jump_target;
  logic [31:0] branch_target;

  assign rs_eq_rt      = (rs_data == rt_data);
  assign rs_le_zero    = rs_data[31] | (rs_data == 32'h0000_0000);
  // Several strobes at once is a decoder fault; any satisfied condition takes the branch
  assign branch_taken  = (beq & rs_eq_rt) | (bne & ~rs_eq_rt) | (blez & rs_le_zero);
  // Register jumps silently drop misaligned low bits
  assign jr_target     = {rs_data[31:2], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};
  assign branch_target = pc_plus4 + branch_offset(instr_index[15:0]);

  // Priority mux over the candidate next-PC values
  always_comb begin
    npc = pc_plus4;
    if (pc_mux_3) begin
      npc = jr_target;
    end else if (!pc_mux_2) begin
      npc = jump_target;
    end else if (branch_taken) begin
      npc = branch_target;
    end else begin
      npc = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / next-PC stage of the multi-cycle MIPS core.
// Fetches one word per instruction over the imem req/ack bus, presents it
// to the decoder for a single EXEC cycle, then loads the next PC. A
// syscall parks the unit in HALT until a go pulse.
// Optional build macro FETCH_STATS_EN adds saturating instruction, branch
// and taken-branch counters of STAT_W bits.
import mips_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          STAT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_unit_if.master       bus,
  output logic [31:0]        instruction,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               pc_mux_2,
  input  logic               pc_mux_3,
  input  logic               beq,
  input  logic               bne,
  input  logic               blez,
  input  logic               syscall,
  input  logic [31:0]        rs_data,
  input  logic [31:0]        rt_data,
  input  logic               go,
  output logic               halted
`ifdef FETCH_STATS_EN
  ,
  output logic [STAT_W-1:0]  instr_cnt,
  output logic [STAT_W-1:0]  branch_cnt,
  output logic [STAT_W-1:0]  taken_cnt
`endif
);

  fetch_state_t state;
  logic         req;
  logic [31:0]  npc;

  // The fetch address is the PC itself, so it is stable for the whole request
  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign pc_plus4      = pc + 32'd4;

`ifdef FETCH_STATS_EN
  logic branch_taken;

  npc_sel u_npc_sel (
    .pc_plus4     (pc_plus4),
    .instr_index  (instruction[25:0]),
    .pc_mux_2     (pc_mux_2),
    .pc_mux_3     (pc_mux_3),
    .beq          (beq),
    .bne          (bne),
    .blez         (blez),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .npc          (npc),
    .branch_taken (branch_taken)
  );
`else
  npc_sel u_npc_sel (
    .pc_plus4     (pc_plus4),
    .instr_index  (instruction[25:0]),
    .pc_mux_2     (pc_mux_2),
    .pc_mux_3     (pc_mux_3),
    .beq          (beq),
    .bne          (bne),
    .blez         (blez),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .npc          (npc),
    .branch_taken ()
  );
`endif

  // Fetch sequencer: state, PC, instruction register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      instruction <= 32'h0000_0000;
      req         <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_FETCH;
          req   <= 1'b1;
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            instruction <= bus.imem_rdata;
            req         <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ST_EXEC;
          end else begin
            req <= 1'b1;
          end
        end
        ST_EXEC: begin
          // The jump/branch target is applied even when a syscall halts the core
          pc          <= npc;
          instr_valid <= 1'b0;
          if (syscall) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            req   <= 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (go) begin
            halted <= 1'b0;
            req    <= 1'b1;
            state  <= ST_FETCH;
          end else begin
            halted <= 1'b1;
          end
        end
        default: begin
          state       <= ST_BOOT;
          req         <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  // Saturating execution statistics, sampled once per EXEC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt  <= {STAT_W{1'b0}};
      branch_cnt <= {STAT_W{1'b0}};
      taken_cnt  <= {STAT_W{1'b0}};
    end else if (state == ST_EXEC) begin
      if (instr_cnt != STAT_MAX) begin
        instr_cnt <= instr_cnt + STAT_ONE;
      end
      if ((beq | bne | blez) && (branch_cnt != STAT_MAX)) begin
        branch_cnt <= branch_cnt + STAT_ONE;
      end
      if (branch_taken && (taken_cnt != STAT_MAX)) begin
        taken_cnt <= taken_cnt + STAT_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The bench plays instruction memory
// and decoder, and predicts fetch addresses with a reference next-PC model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          SW     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction, pc, pc_plus4, rs_data, rt_data;
  logic        instr_valid, halted, pc_mux_2, pc_mux_3, beq, bne, blez, syscall, go;
`ifdef FETCH_STATS_EN
  logic [SW-1:0] instr_cnt, branch_cnt, taken_cnt;
`endif

  int total = 0;
  int bad = 0;

  // reference model state
  logic [31:0] m_pc;
  int          m_icnt, m_bcnt, m_tcnt;

  typedef struct {
    bit          tmo;
    logic [31:0] f_addr;
    int          held;
    logic        v;
    logic [31:0] ins, p, pp4;
    logic        nreq, nvalid, nhalt;
    logic [31:0] naddr;
    logic [31:0] exp_fetch, exp_next;
  } obs_t;

  fetch_unit_if bus ();

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .STAT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .pc_mux_2(pc_mux_2), .pc_mux_3(pc_mux_3),
    .beq(beq), .bne(bne), .blez(blez), .syscall(syscall),
    .rs_data(rs_data), .rt_data(rt_data),
    .go(go), .halted(halted)
`ifdef FETCH_STATS_EN
    , .instr_cnt(instr_cnt), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
`endif
  );

  // Reference next PC straight from the architectural rules
  function automatic logic [31:0] ref_npc(input logic [31:0] cur, ins, input logic m2, m3, b1, b2, b3,
                                          input logic [31:0] rs, rt, output bit tk);
    logic [31:0] seq;
    int off;
    seq = cur + 32'd4;
    tk  = (b1 && rs == rt) || (b2 && rs != rt) || (b3 && $signed(rs) <= 0);
    off = int'($signed(ins[15:0])) * 4;
    if (m3) return (rs / 32'd4) * 32'd4;
    if (!m2) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (tk) return seq + off;
    return seq;
  endfunction

  // Serve one fetch with 'delay' wait cycles, act as decoder for its EXEC, observe outcome
  task automatic run_instr(input logic [31:0] rdata, input int delay, input logic m2, m3, b1, b2, b3, sc,
                           input logic [31:0] rs, rt, output obs_t o);
    int n;
    bit tk;
    o = '{tmo: 1'b0, f_addr: 32'h0, held: 0, v: 1'b0, ins: 32'h0, p: 32'h0, pp4: 32'h0,
          nreq: 1'b0, nvalid: 1'b0, nhalt: 1'b0, naddr: 32'h0, exp_fetch: m_pc, exp_next: 32'h0};
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.imem_req !== 1'b1) begin
      o.tmo = 1'b1;
      return;
    end
    o.f_addr = bus.imem_addr;
    for (int i = 0; i < delay; i++) begin
      if (bus.imem_req === 1'b1 && bus.imem_addr === o.f_addr) o.held++;
      @(negedge clk);
    end
    if (bus.imem_req === 1'b1 && bus.imem_addr === o.f_addr) o.held++;
    pc_mux_2 = m2; pc_mux_3 = m3; beq = b1; bne = b2; blez = b3; syscall = sc;
    rs_data = rs; rt_data = rt;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = rdata;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.imem_rdata = $urandom;
    o.v = instr_valid; o.ins = instruction; o.p = pc; o.pp4 = pc_plus4;
    @(negedge clk);
    o.nreq = bus.imem_req; o.naddr = bus.imem_addr; o.nvalid = instr_valid; o.nhalt = halted;
    // model update
    o.exp_next = ref_npc(m_pc, rdata, m2, m3, b1, b2, b3, rs, rt, tk);
    m_pc = o.exp_next;
    m_icnt++;
    if (b1 || b2 || b3) m_bcnt++;
    if (tk) m_tcnt++;
    // decoder outputs are meaningless outside EXEC
    pc_mux_2 = 1'($urandom); pc_mux_3 = 1'($urandom); beq = 1'($urandom);
    bne = 1'($urandom); blez = 1'($urandom); syscall = 1'($urandom);
    rs_data = $urandom; rt_data = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl req=%b valid=%b halted=%b want 0 0 0", bus.imem_req, instr_valid, halted);
    end
    total++; if (pc !== RST_PC || instruction !== 32'h0) begin
      bad++; $display("FAIL reset_regs pc=%h instr=%h want %h 0", pc, instruction, RST_PC);
    end
    rst_n = 1'b1;
    m_pc = RST_PC; m_icnt = 0; m_bcnt = 0; m_tcnt = 0;
    #1;
    total++; if (bus.imem_req !== 1'b0) begin
      bad++; $display("FAIL boot_cycle req=%b want 0", bus.imem_req);
    end
    @(negedge clk);
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
      bad++; $display("FAIL boot_exit req=%b addr=%h want 1 %h", bus.imem_req, bus.imem_addr, RST_PC);
    end
  endtask

  task automatic test_basic_fetch();
    obs_t o;
    run_instr(32'h2008_0005, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5, 32'h6, o);
    total++; if (o.tmo || o.f_addr !== 32'h0 || o.held != 3) begin
      bad++; $display("FAIL basic_hold tmo=%0d addr=%h held=%0d want 0 0 3", o.tmo, o.f_addr, o.held);
    end
    total++; if (o.v !== 1'b1 || o.nvalid !== 1'b0 || o.ins !== 32'h2008_0005) begin
      bad++; $display("FAIL basic_exec valid=%b next_valid=%b instr=%h want 1 0 20080005", o.v, o.nvalid, o.ins);
    end
    total++; if (o.p !== 32'h0 || o.pp4 !== 32'h4) begin
      bad++; $display("FAIL basic_pc pc=%h pc_plus4=%h want 0 4", o.p, o.pp4);
    end
    total++; if (o.nreq !== 1'b1 || o.naddr !== 32'h4) begin
      bad++; $display("FAIL basic_next req=%b addr=%h want 1 4", o.nreq, o.naddr);
    end
  endtask

  task automatic test_branches();
    obs_t o;
    logic [31:0] want [4];
    want = '{32'h3C, 32'h44, 32'h88, 32'h8C};
    run_instr(32'h0000_0008, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, o);
    run_instr(32'h1022_FFFE, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'd7, o);
    total++; if (o.tmo || o.naddr !== want[0]) begin
      bad++; $display("FAIL beq_taken addr=%h want %h", o.naddr, want[0]);
    end
    run_instr(32'h0000_0008, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, o);
    run_instr(32'h1022_FFFE, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'd8, o);
    total++; if (o.tmo || o.naddr !== want[1]) begin
      bad++; $display("FAIL beq_not_taken addr=%h want %h", o.naddr, want[1]);
    end
    run_instr(32'h1820_0010, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, o);
    total++; if (o.tmo || o.naddr !== want[2]) begin
      bad++; $display("FAIL blez_taken addr=%h want %h", o.naddr, want[2]);
    end
    run_instr(32'h1820_0010, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1, 32'h0, o);
    total++; if (o.tmo || o.naddr !== want[3]) begin
      bad++; $display("FAIL blez_not_taken addr=%h want %h", o.naddr, want[3]);
    end
    run_instr(32'h1422_0004, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1, 32'h2, o);
    total++; if (o.tmo || o.naddr !== 32'hA0) begin
      bad++; $display("FAIL bne_taken addr=%h want 000000a0", o.naddr);
    end
  endtask

  task automatic test_jumps();
    obs_t o;
    run_instr(32'h0000_0008, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000, 32'h0, o);
    total++; if (o.tmo || o.naddr !== 32'h1000_0000) begin
      bad++; $display("FAIL jr_setup addr=%h want 10000000", o.naddr);
    end
    run_instr(32'h0800_0010, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, o);
    total++; if (o.tmo || o.naddr !== 32'h1000_0040 || o.pp4 !== 32'h1000_0004) begin
      bad++; $display("FAIL j_target addr=%h link=%h want 10000040 10000004", o.naddr, o.pp4);
    end
    run_instr(32'h0000_0008, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h123, 32'h0, o);
    total++; if (o.tmo || o.naddr !== 32'h120) begin
      bad++; $display("FAIL jr_misaligned addr=%h want 00000120", o.naddr);
    end
    // JR outranks a J select and a satisfied branch
    run_instr(32'h1000_0004, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h203, 32'h203, o);
    total++; if (o.tmo || o.naddr !== 32'h200) begin
      bad++; $display("FAIL jr_priority addr=%h want 00000200", o.naddr);
    end
  endtask

  task automatic test_syscall();
    obs_t o;
    int good;
    run_instr(32'h0000_0008, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, o);
    run_instr(32'h0000_000C, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, o);
    good = (o.nhalt === 1'b1 && o.nreq === 1'b0) ? 1 : 0;
    go = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.imem_ack = 1'b1;
      bus.imem_rdata = $urandom;
      @(negedge clk);
      if (halted === 1'b1 && bus.imem_req === 1'b0) good++;
    end
    bus.imem_ack = 1'b0;
    total++; if (good != 10) begin
      bad++; $display("FAIL halt_hold good_cycles=%0d want 10", good);
    end
    total++; if (instruction !== 32'h0000_000C) begin
      bad++; $display("FAIL halt_ack_ignored instr=%h want 0000000c", instruction);
    end
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h24 || halted !== 1'b0) begin
      bad++; $display("FAIL resume req=%b addr=%h halted=%b want 1 24 0", bus.imem_req, bus.imem_addr, halted);
    end
    // syscall combined with JR: target applied, then halt
    run_instr(32'h0000_000C, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 32'h0, o);
    total++; if (o.tmo || o.nhalt !== 1'b1 || pc !== 32'h300) begin
      bad++; $display("FAIL syscall_jump halted=%b pc=%h want 1 300", o.nhalt, pc);
    end
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic test_wrap();
    obs_t o;
    run_instr(32'h0000_0008, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, o);
    total++; if (o.tmo || o.f_addr !== 32'h300 || o.naddr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_setup fetch=%h next=%h want 300 fffffffc", o.f_addr, o.naddr);
    end
    run_instr(32'h0123_4020, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, o);
    total++; if (o.tmo || o.pp4 !== 32'h0 || o.naddr !== 32'h0) begin
      bad++; $display("FAIL pc_wrap pc_plus4=%h next=%h want 0 0", o.pp4, o.naddr);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [31:0] ins, rs, rt;
    logic m2, m3, b1, b2, b3, sc;
    int sel;
    for (int k = 0; k < 40; k++) begin
      ins = $urandom;
      m3 = ($urandom_range(0, 5) == 0);
      m2 = ($urandom_range(0, 5) != 0);
      sel = $urandom_range(0, 5);
      b1 = (sel == 1) || (sel == 4);
      b2 = (sel == 2) || (sel == 5);
      b3 = (sel == 3) || (sel == 5);
      sc = ($urandom_range(0, 7) == 0);
      rs = $urandom;
      rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
      if ($urandom_range(0, 3) == 0) rs = 32'h0;
      run_instr(ins, $urandom_range(0, 3), m2, m3, b1, b2, b3, sc, rs, rt, o);
      total++; if (o.tmo || o.f_addr !== o.exp_fetch || o.ins !== ins || o.v !== 1'b1) begin
        bad++; $display("FAIL rand_fetch k=%0d tmo=%0d addr=%h instr=%h valid=%b want %h %h 1",
                        k, o.tmo, o.f_addr, o.ins, o.v, o.exp_fetch, ins);
      end
      total++; if (o.pp4 !== o.exp_fetch + 32'd4) begin
        bad++; $display("FAIL rand_pc_plus4 k=%0d got=%h want %h", k, o.pp4, o.exp_fetch + 32'd4);
      end
      if (sc) begin
        total++; if (o.nhalt !== 1'b1 || o.nreq !== 1'b0 || pc !== o.exp_next) begin
          bad++; $display("FAIL rand_halt k=%0d halted=%b req=%b pc=%h want 1 0 %h", k, o.nhalt, o.nreq, pc, o.exp_next);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
      end else begin
        total++; if (o.nreq !== 1'b1 || o.naddr !== o.exp_next) begin
          bad++; $display("FAIL rand_next k=%0d req=%b addr=%h want 1 %h", k, o.nreq, o.naddr, o.exp_next);
        end
        // go outside HALT must not disturb a pending fetch
        go = 1'($urandom);
        @(negedge clk);
        go = 1'b0;
      end
    end
  endtask

  task automatic test_stats();
`ifdef FETCH_STATS_EN
    int ei, eb, et;
    ei = (m_icnt > 15) ? 15 : m_icnt;
    eb = (m_bcnt > 15) ? 15 : m_bcnt;
    et = (m_tcnt > 15) ? 15 : m_tcnt;
    total++; if (instr_cnt !== SW'(ei) || m_icnt < 20) begin
      bad++; $display("FAIL stat_instr got=%0d want %0d (executed %0d)", instr_cnt, ei, m_icnt);
    end
    total++; if (branch_cnt !== SW'(eb) || taken_cnt !== SW'(et)) begin
      bad++; $display("FAIL stat_branch got=%0d/%0d want %0d/%0d", branch_cnt, taken_cnt, eb, et);
    end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    obs_t o;
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== RST_PC) begin
      bad++; $display("FAIL async_reset req=%b valid=%b pc=%h want 0 0 %h", bus.imem_req, instr_valid, pc, RST_PC);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc = RST_PC; m_icnt = 0; m_bcnt = 0; m_tcnt = 0;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC || instruction !== 32'h0) begin
      bad++; $display("FAIL late_ack req=%b addr=%h instr=%h want 1 %h 0", bus.imem_req, bus.imem_addr, instruction, RST_PC);
    end
    run_instr(32'h2008_0005, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, o);
    total++; if (o.tmo || o.f_addr !== RST_PC || o.naddr !== RST_PC + 32'd4) begin
      bad++; $display("FAIL restart fetch=%h next=%h want %h %h", o.f_addr, o.naddr, RST_PC, RST_PC + 32'd4);
    end
`ifdef FETCH_STATS_EN
    total++; if (instr_cnt !== SW'(1)) begin
      bad++; $display("FAIL stat_after_reset got=%0d want 1", instr_cnt);
    end
`endif
  endtask

  initial begin
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    pc_mux_2 = 1'b1; pc_mux_3 = 1'b0; beq = 1'b0; bne = 1'b0; blez = 1'b0; syscall = 1'b0;
    rs_data = 32'h0; rt_data = 32'h0; go = 1'b0;
    m_pc = RST_PC; m_icnt = 0; m_bcnt = 0; m_tcnt = 0;
    @(negedge clk);
    test_reset();
    test_basic_fetch();
    test_branches();
    test_jumps();
    test_syscall();
    test_wrap();
    test_random();
    test_stats();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
